// File: rtl/trig_event_pkg.sv
// Shared types and constants for the L1 trigger event builder.
package trig_event_pkg;

  localparam int TIME_BITS_DEF = 32;
  localparam int NBEAMS_DEF    = 2;
  localparam int DROP_BITS     = 16;

  // One queued event at the default widths: first-hit time above the merged beam mask.
  typedef struct packed {
    logic [TIME_BITS_DEF-1:0] tstamp;
    logic [NBEAMS_DEF-1:0]    mask;
  } trig_event_t;

  // Event builder FSM encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    PUSH   = 2'd2
  } evt_state_e;

endpackage

// File: rtl/trig_event_fifo.sv
// First-word-fall-through event queue; all event storage lives here.
module trig_event_fifo
  import trig_event_pkg::*;
#(
  parameter int WIDTH = TIME_BITS_DEF + NBEAMS_DEF,
  parameter int DEPTH = 16
) (
  input  logic                   aclk,
  input  logic                   reset_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push into a full queue is still taken.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // Head word is shown as zero while the queue is empty so a flushed queue reads clean.
  assign dout = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because empty masks the head word.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/l1_trigger_event_builder.sv
// Merges beam trigger hits inside a fixed coincidence window into queued events.
module l1_trigger_event_builder
  import trig_event_pkg::*;
#(
  parameter int NBEAMS        = 2,
  parameter int WINDOW_CLOCKS = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int TIME_BITS     = 32
) (
  input  logic                          aclk,
  input  logic                          reset_i,
  input  logic [NBEAMS-1:0]             trig_i,
  input  logic                          enable_i,
  output logic [TIME_BITS+NBEAMS-1:0]   evt_tdata_o,
  output logic                          evt_tvalid_o,
  input  logic                          evt_tready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [DROP_BITS-1:0]          drop_count_o,
  output logic [TIME_BITS-1:0]          timestamp_o
);

  localparam int                 CNT_BITS = $clog2(WINDOW_CLOCKS);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(WINDOW_CLOCKS - 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_GATHER = GATHER;
  localparam logic [1:0] ST_PUSH   = PUSH;

  logic [1:0]           state;
  logic [TIME_BITS-1:0] ts;
  logic [TIME_BITS-1:0] evt_time;
  logic [NBEAMS-1:0]    evt_mask;
  logic [CNT_BITS-1:0]  cnt;
  logic                 start_evt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 fifo_push;

  assign start_evt    = enable_i && (|trig_i);
  assign evt_tvalid_o = !fifo_empty;
  assign fifo_pop     = evt_tvalid_o && evt_tready_i;
  assign fifo_push    = (state == ST_PUSH) && (!fifo_full || fifo_pop);
  assign timestamp_o  = ts;

  // Free-running timestamp, wraps naturally at its width.
  always_ff @(posedge aclk) begin
    if (reset_i) ts <= '0;
    else         ts <= ts + 1'b1;
  end

  // Event FSM: open on a hit, OR in hits for the window, then hand off in PUSH.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      evt_time <= '0;
      evt_mask <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_evt) begin
            evt_time <= ts;
            evt_mask <= trig_i;
            cnt      <= CNT_LOAD;
            state    <= ST_GATHER;
          end
        end
        ST_GATHER: begin
          evt_mask <= evt_mask | trig_i;
          cnt      <= cnt - 1'b1;
          if (cnt == CNT_LAST) state <= ST_PUSH;
        end
        ST_PUSH: begin
          if (start_evt) begin
            evt_time <= ts;
            evt_mask <= trig_i;
            cnt      <= CNT_LOAD;
            state    <= ST_GATHER;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Count events that found the queue full, holding at the maximum.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      drop_count_o <= '0;
    end else if ((state == ST_PUSH) && !fifo_push && (drop_count_o != '1)) begin
      drop_count_o <= drop_count_o + 1'b1;
    end
  end

  trig_event_fifo #(
    .WIDTH (TIME_BITS + NBEAMS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .reset_i (reset_i),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     ({evt_time, evt_mask}),
    .dout    (evt_tdata_o),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_o)
  );

endmodule
